// File: rtl/vend_pkg.sv
// vend_pkg: shared state, coin codes and coin value helper for the credit controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;
  localparam logic [1:0] COIN_SLUG    = 2'b11;
  localparam logic [3:0] BLANK = 4'hA;
  function automatic logic [7:0] coin_value(input logic [1:0] code);
    return code == COIN_NICKEL  ? 8'd5  :
           code == COIN_DIME    ? 8'd10 :
           code == COIN_QUARTER ? 8'd25 : 8'd0;
  endfunction
endpackage

// File: rtl/vend_credit_ctrl_digit_split.sv
// digit_split: sequential divide-by-10 that turns credit into two display digits
module digit_split
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_value,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0,
  output logic       o_busy
);
  logic [7:0] r_last, r_work;
  logic [3:0] r_tens, r_d1, r_d0;
  logic       r_busy;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 8'd0;
      r_work <= 8'd0;
      r_tens <= 4'd0;
      r_busy <= 1'b0;
      r_d1   <= BLANK;
      r_d0   <= BLANK;
    end else if (i_value != r_last) begin
      r_last <= i_value;
      r_work <= i_value;
      r_tens <= 4'd0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_work >= 8'd10) begin
        r_work <= r_work - 8'd10;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_busy <= 1'b0;
        r_d1   <= r_tens == 4'd0 ? BLANK : r_tens;
        r_d0   <= r_work[3:0];
      end
    end
  end
  assign o_d1   = r_d1;
  assign o_d0   = r_d0;
  assign o_busy = r_busy;
endmodule

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit, purchase and one-coin-at-a-time change payout
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = 75
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_type,
  output logic       o_coin_accept,
  output logic       o_coin_reject,
  input  logic       i_buy,
  input  logic [7:0] i_price,
  input  logic       i_cancel,
  output logic       o_vend,
  output logic       o_short_funds,
  output logic       o_change_valid,
  output logic [1:0] o_change_coin,
  input  logic       i_change_ready,
  output logic [7:0] o_credit,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0,
  output logic       o_disp_busy
);
  state_t     r_state, w_next;
  logic [7:0] r_credit, w_credit;
  logic [8:0] w_sum;
  logic [1:0] r_change_coin, w_coin;
  logic       r_coin_accept, r_coin_reject, r_short_funds, r_vend, r_change_valid;
  logic       w_acc, w_rej, w_sf;
  assign w_sum  = {1'b0, r_credit} + {1'b0, coin_value(i_coin_type)};
  assign w_coin = w_credit >= 8'd25 ? COIN_QUARTER : w_credit >= 8'd10 ? COIN_DIME : COIN_NICKEL;
  always_comb begin
    w_next   = r_state;
    w_credit = r_credit;
    w_acc    = 1'b0;
    w_rej    = 1'b0;
    w_sf     = 1'b0;
    if (r_state == IDLE) begin
      if (i_cancel && r_credit != 8'd0) begin
        w_next = CHANGE;
        w_rej  = i_coin_valid;
      end else if (i_buy) begin
        w_rej = i_coin_valid;
        if (i_price != 8'd0 && {1'b0, r_credit} >= {1'b0, i_price}) begin
          w_credit = r_credit - i_price;
          w_next   = VEND;
        end else
          w_sf = 1'b1;
      end else if (i_coin_valid) begin
        if (i_coin_type != COIN_SLUG && w_sum <= 9'(MAX_CREDIT)) begin
          w_acc    = 1'b1;
          w_credit = w_sum[7:0];
        end else
          w_rej = 1'b1;
      end
    end else begin
      // busy paying out or vending: every coin goes straight back
      w_rej = i_coin_valid;
      if (r_state == VEND)
        w_next = r_credit != 8'd0 ? CHANGE : IDLE;
      else if (r_change_valid && i_change_ready) begin
        w_credit = r_credit - coin_value(r_change_coin);
        w_next   = w_credit == 8'd0 ? IDLE : CHANGE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_credit       <= 8'd0;
      r_coin_accept  <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_short_funds  <= 1'b0;
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NICKEL;
    end else begin
      r_state        <= w_next;
      r_credit       <= w_credit;
      r_coin_accept  <= w_acc;
      r_coin_reject  <= w_rej;
      r_short_funds  <= w_sf;
      r_vend         <= w_next == VEND;
      r_change_valid <= w_next == CHANGE;
      r_change_coin  <= w_coin;
    end
  end
  digit_split u_split (
    .clk    (clk),
    .reset  (reset),
    .i_value(r_credit),
    .o_d1   (o_d1),
    .o_d0   (o_d0),
    .o_busy (o_disp_busy)
  );
  assign o_coin_accept  = r_coin_accept;
  assign o_coin_reject  = r_coin_reject;
  assign o_short_funds  = r_short_funds;
  assign o_vend         = r_vend;
  assign o_change_valid = r_change_valid;
  assign o_change_coin  = r_change_coin;
  assign o_credit       = r_credit;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed checks of coin, buy, change and display behaviour
module tb_vend_credit_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic       i_coin_valid = 1'b0, i_buy = 1'b0, i_cancel = 1'b0, i_change_ready = 1'b0;
  logic [1:0] i_coin_type = 2'b00;
  logic [7:0] i_price = 8'd0;
  logic       o_coin_accept, o_coin_reject, o_vend, o_short_funds, o_change_valid, o_disp_busy;
  logic [1:0] o_change_coin;
  logic [7:0] o_credit;
  logic [3:0] o_d1, o_d0;
  int total = 0, bad = 0;

  vend_credit_ctrl #(.MAX_CREDIT(75)) dut (
    .clk(clk), .reset(reset),
    .i_coin_valid(i_coin_valid), .i_coin_type(i_coin_type),
    .o_coin_accept(o_coin_accept), .o_coin_reject(o_coin_reject),
    .i_buy(i_buy), .i_price(i_price), .i_cancel(i_cancel),
    .o_vend(o_vend), .o_short_funds(o_short_funds),
    .o_change_valid(o_change_valid), .o_change_coin(o_change_coin),
    .i_change_ready(i_change_ready), .o_credit(o_credit),
    .o_d1(o_d1), .o_d0(o_d0), .o_disp_busy(o_disp_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [1:0] t);
    i_coin_valid = 1'b1;
    i_coin_type  = t;
    tick();
    i_coin_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_credit", o_credit, 0);
    check("rst_d1", o_d1, 4'hA);
    check("rst_d0", o_d0, 4'hA);
    check("rst_cv", o_change_valid, 0);
    check("rst_vend", o_vend, 0);
    coin(2'b00);
    check("nickel_acc", o_coin_accept, 1);
    check("nickel_credit", o_credit, 5);
    coin(2'b01);
    check("dime_acc", o_coin_accept, 1);
    check("dime_credit", o_credit, 15);
    coin(2'b10);
    check("quarter_acc", o_coin_accept, 1);
    check("quarter_rej", o_coin_reject, 0);
    check("credit40", o_credit, 40);
    repeat (5) tick();
    check("disp40_early_d1", o_d1, 4'hA);
    tick();
    check("disp40_d1", o_d1, 4);
    check("disp40_d0", o_d0, 0);
    coin(2'b11);
    check("slug_rej", o_coin_reject, 1);
    check("slug_acc", o_coin_accept, 0);
    check("slug_credit", o_credit, 40);
    coin(2'b10);
    check("credit65", o_credit, 65);
    i_change_ready = 1'b1;
    i_buy = 1'b1; i_price = 8'd25;
    tick();
    i_buy = 1'b0;
    check("buy_vend", o_vend, 1);
    check("buy_credit", o_credit, 40);
    check("buy_cv_low", o_change_valid, 0);
    tick();
    check("pay_vend_off", o_vend, 0);
    check("pay1_cv", o_change_valid, 1);
    check("pay1_coin", o_change_coin, 2'b10);
    check("pay1_credit", o_credit, 40);
    tick();
    check("pay2_coin", o_change_coin, 2'b01);
    check("pay2_credit", o_credit, 15);
    tick();
    check("pay3_coin", o_change_coin, 2'b00);
    check("pay3_credit", o_credit, 5);
    tick();
    check("pay_done_credit", o_credit, 0);
    check("pay_done_cv", o_change_valid, 0);
    i_change_ready = 1'b0;
    tick(); tick();
    check("disp0_d1", o_d1, 4'hA);
    check("disp0_d0", o_d0, 0);
    coin(2'b01); coin(2'b01);
    check("credit20", o_credit, 20);
    i_buy = 1'b1; i_price = 8'd35;
    tick();
    i_buy = 1'b0;
    check("short_sf", o_short_funds, 1);
    check("short_vend", o_vend, 0);
    check("short_credit", o_credit, 20);
    i_buy = 1'b1; i_price = 8'd0;
    tick();
    i_buy = 1'b0;
    check("price0_sf", o_short_funds, 1);
    check("price0_vend", o_vend, 0);
    tick();
    check("sf_pulse_once", o_short_funds, 0);
    coin(2'b01);
    check("credit30", o_credit, 30);
    i_cancel = 1'b1;
    tick();
    i_cancel = 1'b0;
    check("cancel_cv", o_change_valid, 1);
    check("cancel_coin", o_change_coin, 2'b10);
    check("cancel_credit", o_credit, 30);
    coin(2'b00);
    check("chg_coin_rej", o_coin_reject, 1);
    check("chg_coin_credit", o_credit, 30);
    check("stall_coin1", o_change_coin, 2'b10);
    tick();
    check("stall_coin2", o_change_coin, 2'b10);
    check("stall_cv", o_change_valid, 1);
    i_change_ready = 1'b1;
    tick();
    check("cancel_pay1_credit", o_credit, 5);
    check("cancel_pay1_coin", o_change_coin, 2'b00);
    tick();
    check("cancel_done_credit", o_credit, 0);
    check("cancel_done_cv", o_change_valid, 0);
    i_change_ready = 1'b0;
    coin(2'b10); coin(2'b10);
    check("credit50", o_credit, 50);
    i_cancel = 1'b1; i_buy = 1'b1; i_price = 8'd10; i_coin_valid = 1'b1; i_coin_type = 2'b00;
    tick();
    i_cancel = 1'b0; i_buy = 1'b0; i_coin_valid = 1'b0;
    check("combo_rej", o_coin_reject, 1);
    check("combo_acc", o_coin_accept, 0);
    check("combo_vend", o_vend, 0);
    check("combo_sf", o_short_funds, 0);
    check("combo_cv", o_change_valid, 1);
    check("combo_credit", o_credit, 50);
    tick();
    check("combo_vend_later", o_vend, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_credit", o_credit, 0);
    check("arst_cv", o_change_valid, 0);
    check("arst_d1", o_d1, 4'hA);
    check("arst_d0", o_d0, 4'hA);
    tick();
    reset = 1'b0;
    tick();
    coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b01);
    check("credit70", o_credit, 70);
    coin(2'b10);
    check("over_rej", o_coin_reject, 1);
    check("over_credit", o_credit, 70);
    coin(2'b00);
    check("max_acc", o_coin_accept, 1);
    check("max_credit", o_credit, 75);
    coin(2'b00);
    check("max_rej", o_coin_reject, 1);
    check("max_hold", o_credit, 75);
    repeat (7) tick();
    check("disp75_early_d1", o_d1, 4'hA);
    tick();
    check("disp75_d1", o_d1, 7);
    check("disp75_d0", o_d0, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
